// File: rtl/gfp8_result_fp16_packer.sv
// Converts GFP results (M x 2^E) to FP16, packs them into OUT_WIDTH-bit lines and
// buffers complete lines in a small FIFO; input is never backpressured.
module gfp8_result_fp16_packer #(
    parameter int OUT_WIDTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [31:0]                       i_result_mantissa,
    input  logic [7:0]                        i_result_exponent,
    input  logic                              i_result_valid,
    input  logic                              i_flush,
    output logic [OUT_WIDTH-1:0]              o_line_data,
    output logic [$clog2(OUT_WIDTH/16):0]     o_line_lanes,
    output logic                              o_line_valid,
    input  logic                              i_line_ready,
    output logic                              o_overflow,
    output logic                              o_idle
);
    localparam int LANES = OUT_WIDTH / 16;
    localparam int CW    = $clog2(LANES);
    localparam int LW    = CW + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Truncating FP16 conversion without subnormals or infinity.
    function automatic logic [15:0] to_fp16(input logic sign, input logic [31:0] mag,
                                            input logic zero, input logic [7:0] e);
        logic [4:0] p;
        logic [9:0] ef;
        logic [9:0] frac;
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                p = i[4:0];
            end else begin
                p = p;
            end
        end
        ef   = {5'b0, p} + {{2{e[7]}}, e} + 10'd15;
        frac = 10'({mag, 10'b0} >> p);
        if (zero) begin
            to_fp16 = 16'h0000;
        end else if (ef[9] || (ef == 10'd0)) begin
            to_fp16 = {sign, 15'h0000};
        end else if (ef >= 10'd31) begin
            to_fp16 = {sign, 15'h7BFF};
        end else begin
            to_fp16 = {sign, ef[4:0], frac};
        end
    endfunction

    logic                 s1_valid_q, s1_flush_q, s1_sign_q, s1_zero_q;
    logic [31:0]          s1_mag_q;
    logic [7:0]           s1_exp_q;
    logic                 s2_valid_q, s2_flush_q;
    logic [15:0]          s2_fp16_q;
    logic [OUT_WIDTH-1:0] line_q, line_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 push_s;
    logic [OUT_WIDTH-1:0] push_data_s;
    logic [LW-1:0]        push_lanes_s;
    logic [OUT_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [LW-1:0]        mem_lanes_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 overflow_q;
    logic                 empty_s, full_s, pop_s, accept_s;

    // S1: capture sign/magnitude of the incoming result alongside the flush flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mag_q   <= 32'd0;
            s1_exp_q   <= 8'd0;
        end else begin
            s1_valid_q <= i_result_valid;
            s1_flush_q <= i_flush;
            if (i_result_valid) begin
                s1_sign_q <= i_result_mantissa[31];
                s1_zero_q <= (i_result_mantissa == 32'd0);
                s1_mag_q  <= i_result_mantissa[31] ? (~i_result_mantissa + 32'd1) : i_result_mantissa;
                s1_exp_q  <= i_result_exponent;
            end
        end
    end

    // S2: hold the converted FP16 value for packing.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_valid_q <= 1'b0;
            s2_flush_q <= 1'b0;
            s2_fp16_q  <= 16'h0000;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_flush_q <= s1_flush_q;
            if (s1_valid_q) begin
                s2_fp16_q <= to_fp16(s1_sign_q, s1_mag_q, s1_zero_q, s1_exp_q);
            end
        end
    end

    // Lane packing; a flush sees the lane count after this cycle's sample.
    always_comb begin
        line_d       = line_q;
        cnt_d        = cnt_q;
        push_s       = 1'b0;
        push_data_s  = '0;
        push_lanes_s = '0;
        if (s2_valid_q) begin
            for (int k = 0; k < LANES; k++) begin
                if (cnt_q == k[CW-1:0]) begin
                    line_d[16*k +: 16] = s2_fp16_q;
                end else begin
                    line_d[16*k +: 16] = line_d[16*k +: 16];
                end
            end
            if (cnt_q == CW'(LANES - 1)) begin
                push_s       = 1'b1;
                push_data_s  = line_d;
                push_lanes_s = LW'(LANES);
                line_d       = '0;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (s2_flush_q && (cnt_d != '0)) begin
            push_s       = 1'b1;
            push_data_s  = line_d;
            push_lanes_s = {1'b0, cnt_d};
            line_d       = '0;
            cnt_d        = '0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop_s    = !empty_s && i_line_ready;
    assign accept_s = push_s && (!full_s || pop_s);

    // Packing state, FIFO pointers and the sticky drop flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            line_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
            if (accept_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            if (push_s && !accept_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Line storage.
    always_ff @(posedge i_clk) begin
        if (accept_s) begin
            mem_data_q[wr_ptr_q[AW-1:0]]  <= push_data_s;
            mem_lanes_q[wr_ptr_q[AW-1:0]] <= push_lanes_s;
        end
    end

    assign o_line_valid = !empty_s;
    assign o_line_data  = empty_s ? '0 : mem_data_q[rd_ptr_q[AW-1:0]];
    assign o_line_lanes = empty_s ? '0 : mem_lanes_q[rd_ptr_q[AW-1:0]];
    assign o_overflow   = overflow_q;
    assign o_idle       = !s1_valid_q && !s2_valid_q && (cnt_q == '0) && empty_s;
endmodule

// File: tb/tb_gfp8_result_fp16_packer.sv
// Directed bench for gfp8_result_fp16_packer with hand-computed FP16 values.
module tb_gfp8_result_fp16_packer;
    logic         clk = 1'b0;
    logic         i_reset;
    logic [31:0]  i_result_mantissa;
    logic [7:0]   i_result_exponent;
    logic         i_result_valid;
    logic         i_flush;
    logic [255:0] o_line_data;
    logic [4:0]   o_line_lanes;
    logic         o_line_valid;
    logic         i_line_ready;
    logic         o_overflow;
    logic         o_idle;

    int errors = 0;
    int checks = 0;
    logic [15:0] ov_exp [5] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};

    gfp8_result_fp16_packer #(.OUT_WIDTH(256), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_result_mantissa(i_result_mantissa), .i_result_exponent(i_result_exponent),
        .i_result_valid(i_result_valid), .i_flush(i_flush),
        .o_line_data(o_line_data), .o_line_lanes(o_line_lanes), .o_line_valid(o_line_valid),
        .i_line_ready(i_line_ready), .o_overflow(o_overflow), .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] m, input logic [7:0] e, input logic fl);
        i_result_mantissa = m;
        i_result_exponent = e;
        i_result_valid    = 1'b1;
        i_flush           = fl;
        step();
        i_result_valid    = 1'b0;
        i_flush           = 1'b0;
    endtask

    task automatic wait_line();
        int n = 0;
        while (!o_line_valid && n < 20) begin
            step();
            n++;
        end
        chk("line_valid_timeout", {255'd0, o_line_valid}, 256'd1);
    endtask

    task automatic pop();
        i_line_ready = 1'b1;
        step();
        i_line_ready = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [31:0] m, input logic [7:0] e,
                        input logic [15:0] exp);
        send(m, e, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        wait_line();
        chk(tag, o_line_data, {240'd0, exp});
        chk({tag, "_lanes"}, {251'd0, o_line_lanes}, 256'd1);
        pop();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        step();
    endtask

    initial begin
        i_reset = 1'b1;
        i_result_mantissa = 32'd0;
        i_result_exponent = 8'd0;
        i_result_valid = 1'b0;
        i_flush = 1'b0;
        i_line_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {255'd0, o_line_valid}, 256'd0);
        chk("rst_data", o_line_data, 256'd0);
        chk("rst_lanes", {251'd0, o_line_lanes}, 256'd0);
        chk("rst_overflow", {255'd0, o_overflow}, 256'd0);
        chk("rst_idle", {255'd0, o_idle}, 256'd1);
        i_reset = 1'b0;
        step();

        conv("c_one", 32'h0000_0001, 8'h00, 16'h3C00);
        conv("c_neg3", 32'hFFFF_FFFD, 8'hFF, 16'hBE00);
        conv("c_min", 32'h8000_0000, 8'hE1, 16'hBC00);
        conv("c_sat", 32'h7FFF_FFFF, 8'h00, 16'h7BFF);
        conv("c_under", 32'h0000_0001, 8'hE7, 16'h0000);
        conv("c_zero", 32'h0000_0000, 8'h05, 16'h0000);
        conv("c_ef31", 32'h0000_0001, 8'h10, 16'h7BFF);
        conv("c_ef30", 32'h0000_0001, 8'h0F, 16'h7800);
        conv("c_ef0", 32'h0000_0001, 8'hF1, 16'h0000);
        conv("c_ef1", 32'h0000_0001, 8'hF2, 16'h0400);
        conv("c_negund", 32'hFFFF_FFFF, 8'hEC, 16'h8000);
        conv("c_five", 32'h0000_0005, 8'h00, 16'h4500);

        // Full line of 16 back-to-back results.
        for (int k = 0; k < 16; k++) send(32'(k + 1), 8'h00, 1'b0);
        chk("full_lat0", {255'd0, o_line_valid}, 256'd0);
        step();
        chk("full_lat1", {255'd0, o_line_valid}, 256'd0);
        step();
        chk("full_lat2", {255'd0, o_line_valid}, 256'd1);
        chk("full_lanes", {251'd0, o_line_lanes}, 256'd16);
        chk("full_l0", {240'd0, o_line_data[15:0]}, 256'h3C00);
        chk("full_l1", {240'd0, o_line_data[31:16]}, 256'h4000);
        chk("full_l2", {240'd0, o_line_data[47:32]}, 256'h4200);
        chk("full_l15", {240'd0, o_line_data[255:240]}, 256'h4C00);
        pop();
        chk("full_single", {255'd0, o_line_valid}, 256'd0);

        // Partial line: flush together with the 5th sample.
        for (int k = 0; k < 5; k++) send(32'(k + 1), 8'h00, (k == 4));
        wait_line();
        chk("part_lanes", {251'd0, o_line_lanes}, 256'd5);
        chk("part_low", {176'd0, o_line_data[79:0]},
            {176'd0, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00});
        chk("part_high", {80'd0, o_line_data[255:80]}, 256'd0);
        pop();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("empty_flush", {255'd0, o_line_valid}, 256'd0);
        chk("empty_idle", {255'd0, o_idle}, 256'd1);

        // Overflow: five lines into a four-deep FIFO.
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 16; k++) send(32'(j + 1), 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step();
        chk("ovf_set", {255'd0, o_overflow}, 256'd1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf_l0_%0d", j), {240'd0, o_line_data[15:0]}, {240'd0, ov_exp[j]});
            chk($sformatf("ovf_l15_%0d", j), {240'd0, o_line_data[255:240]}, {240'd0, ov_exp[j]});
            chk($sformatf("ovf_lanes_%0d", j), {251'd0, o_line_lanes}, 256'd16);
            pop();
        end
        chk("ovf_drained", {255'd0, o_line_valid}, 256'd0);
        chk("ovf_sticky", {255'd0, o_overflow}, 256'd1);

        // Same fill, but the consumer pops in the push cycle of the 5th line.
        do_reset();
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 16; k++) send(32'(j + 1), 8'h00, 1'b0);
        step();
        i_line_ready = 1'b1;
        step();
        i_line_ready = 1'b0;
        step();
        chk("nodrop_ovf", {255'd0, o_overflow}, 256'd0);
        for (int j = 1; j < 5; j++) begin
            chk($sformatf("nodrop_l0_%0d", j), {240'd0, o_line_data[15:0]}, {240'd0, ov_exp[j]});
            pop();
        end
        chk("nodrop_drained", {255'd0, o_line_valid}, 256'd0);

        // Asynchronous reset with a queued line and a partial line.
        for (int k = 0; k < 16; k++) send(32'd7, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) send(32'd9, 8'h00, 1'b0);
        step();
        chk("pre_rst_valid", {255'd0, o_line_valid}, 256'd1);
        chk("pre_rst_idle", {255'd0, o_idle}, 256'd0);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_valid", {255'd0, o_line_valid}, 256'd0);
        chk("arst_data", o_line_data, 256'd0);
        chk("arst_lanes", {251'd0, o_line_lanes}, 256'd0);
        chk("arst_idle", {255'd0, o_idle}, 256'd1);
        step();
        i_reset = 1'b0;
        step();
        for (int k = 0; k < 16; k++) send(32'(k + 1), 8'h00, 1'b0);
        wait_line();
        chk("clean_lanes", {251'd0, o_line_lanes}, 256'd16);
        chk("clean_l0", {240'd0, o_line_data[15:0]}, 256'h3C00);
        chk("clean_l3", {240'd0, o_line_data[63:48]}, 256'h4400);
        chk("clean_l15", {240'd0, o_line_data[255:240]}, 256'h4C00);
        pop();
        for (int k = 0; k < 3; k++) step();
        chk("clean_single", {255'd0, o_line_valid}, 256'd0);
        chk("clean_idle", {255'd0, o_idle}, 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
